// File: rtl/reset_sequencer_if.sv
// Board reset sequencer bundle: PLL lock inputs, software/watchdog controls, sequenced domain resets.
// master = board/environment side, slave = the sequencer.
interface reset_sequencer_if #(
    parameter int N_LOCK    = 2,
    parameter int N_DOMAINS = 3
);
    logic [N_LOCK-1:0]    locked;
    logic                 force_rst;
    logic                 wdog_kick;
    logic [N_DOMAINS-1:0] rst_n_out;
    logic                 all_released;
    logic [1:0]           state;
    logic                 wdog_fired;

    modport master (
        output locked, force_rst, wdog_kick,
        input  rst_n_out, all_released, state, wdog_fired
    );

    modport slave (
        input  locked, force_rst, wdog_kick,
        output rst_n_out, all_released, state, wdog_fired
    );
endinterface

// File: rtl/reset_sequencer.sv
// Waits for debounced PLL lock, then releases domain resets in ascending order STAGE_CYCLES apart.
// Optional RUN-state watchdog enabled by defining RESET_SEQ_WDOG_EN.
module reset_sequencer #(
    parameter int N_LOCK       = 2,
    parameter int N_DOMAINS    = 3,
    parameter int LOCK_FILTER  = 16,
    parameter int STAGE_CYCLES = 100,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    reset_sequencer_if.slave   bus
);
    localparam int CNT_AB  = (LOCK_FILTER > STAGE_CYCLES) ? LOCK_FILTER : STAGE_CYCLES;
    localparam int CNT_MAX = (CNT_AB > WDOG_CYCLES) ? CNT_AB : WDOG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int STG_W   = $clog2(N_DOMAINS) + 1;

    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STG_W-1:0] DOM_LAST   = STG_W'(N_DOMAINS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t               st, st_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [STG_W-1:0]     stage, stage_d;
    logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                 all_rel_q, all_rel_d;
    logic                 wdog_abort;

`ifdef RESET_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    logic [CNT_W-1:0] wcnt, wcnt_d;
    logic             wfired, wfired_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= '0;
            wfired <= 1'b0;
        end else begin
            wcnt   <= wcnt_d;
            wfired <= wfired_d;
        end
    end

    assign bus.wdog_fired = wfired;
`else
    logic unused_kick;
    assign unused_kick    = bus.wdog_kick;
    assign bus.wdog_fired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= WAIT_LOCK;
            cnt       <= '0;
            stage     <= '0;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
        end else begin
            st        <= st_d;
            cnt       <= cnt_d;
            stage     <= stage_d;
            rst_n_q   <= rst_n_d;
            all_rel_q <= all_rel_d;
        end
    end

    always_comb begin
        st_d       = st;
        cnt_d      = cnt;
        stage_d    = stage;
        rst_n_d    = rst_n_q;
        all_rel_d  = all_rel_q;
        wdog_abort = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
        wcnt_d   = '0;
        wfired_d = wfired;
        if (st == RUN) begin
            if (bus.wdog_kick)
                wcnt_d = '0;
            else if (wcnt == WDOG_LAST)
                wdog_abort = 1'b1;
            else
                wcnt_d = wcnt + CNT_W'(1);
        end
`endif
        // Abort outranks every timer: all domains drop together and sequencing starts over.
        if (bus.force_rst || !(&bus.locked) || wdog_abort) begin
            st_d      = WAIT_LOCK;
            cnt_d     = '0;
            stage_d   = '0;
            rst_n_d   = '0;
            all_rel_d = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
            wcnt_d = '0;
            if (wdog_abort)
                wfired_d = 1'b1;
`endif
        end else begin
            case (st)
                WAIT_LOCK: begin
                    st_d  = FILTER;
                    cnt_d = '0;
                end
                FILTER: begin
                    if (cnt == FILT_LAST) begin
                        st_d    = RELEASE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        for (int k = 0; k < N_DOMAINS; k++)
                            if (STG_W'(k) == stage)
                                rst_n_d[k] = 1'b1;
                        cnt_d   = '0;
                        stage_d = stage + STG_W'(1);
                        if (stage == DOM_LAST) begin
                            st_d      = RUN;
                            all_rel_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    st_d = RUN;
                end
                default: begin
                    st_d = WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.rst_n_out    = rst_n_q;
    assign bus.all_released = all_rel_q;
    assign bus.state        = st;
endmodule
